// File: rtl/inferencia_nie_tan.sv
// inferencia_nie_tan: type-2 fuzzy 3x3 min-rule inference with Nie-Tan reduction,
// accumulating one rule per cycle and dividing with a 21-step restoring divider.
module inferencia_nie_tan #(
    parameter logic [7:0]  Y1           = 8'd40,
    parameter logic [7:0]  Y2           = 8'd128,
    parameter logic [7:0]  Y3           = 8'd215,
    parameter logic [17:0] RULE_MAP     = 18'h29910,
    parameter logic [7:0]  SAIDA_PADRAO = 8'd128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicio,
    input  logic [7:0] A_MF_01_UP,
    input  logic [7:0] A_MF_01_LOW,
    input  logic [7:0] A_MF_02_UP,
    input  logic [7:0] A_MF_02_LOW,
    input  logic [7:0] A_MF_03_UP,
    input  logic [7:0] A_MF_03_LOW,
    input  logic [7:0] B_MF_01_UP,
    input  logic [7:0] B_MF_01_LOW,
    input  logic [7:0] B_MF_02_UP,
    input  logic [7:0] B_MF_02_LOW,
    input  logic [7:0] B_MF_03_UP,
    input  logic [7:0] B_MF_03_LOW,
    output logic [7:0] saida,
    output logic       valido,
    output logic       ocupado
);
    typedef enum logic [1:0] {IDLE, ACUM, DIV, FIM} state_t;
    state_t      state;
    logic [7:0]  a_up [3];
    logic [7:0]  a_low [3];
    logic [7:0]  b_up [3];
    logic [7:0]  b_low [3];
    logic [4:0]  cnt;
    logic [20:0] num;
    logic [20:0] quo;
    logic [12:0] den;
    logic [12:0] rem;
    logic [3:0]  r;
    logic [1:0]  ri;
    logic [1:0]  rj;
    logic [1:0]  sel;
    logic [7:0]  f_up;
    logic [7:0]  f_low;
    logic [7:0]  y;
    logic [8:0]  w;
    logic [16:0] prod;
    logic [13:0] rem_sh;
    logic        ge;
    // Rule index is forced to 0 outside ACUM so the membership lookups stay in range.
    always_comb begin
        r      = state == ACUM ? cnt[3:0] : 4'd0;
        ri     = r >= 4'd6 ? 2'd2 : r >= 4'd3 ? 2'd1 : 2'd0;
        rj     = 2'(r - {2'b0, ri} - {1'b0, ri, 1'b0});
        sel    = 2'(RULE_MAP >> {r, 1'b0});
        f_up   = a_up[ri] < b_up[rj] ? a_up[ri] : b_up[rj];
        f_low  = a_low[ri] < b_low[rj] ? a_low[ri] : b_low[rj];
        y      = sel == 2'd0 ? Y1 : sel == 2'd1 ? Y2 : Y3;
        w      = sel == 2'd3 ? 9'd0 : {1'b0, f_up} + {1'b0, f_low};
        prod   = w * y;
        rem_sh = {rem, num[20]};
        ge     = rem_sh >= {1'b0, den};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            num     <= '0;
            quo     <= '0;
            den     <= '0;
            rem     <= '0;
            saida   <= '0;
            valido  <= 1'b0;
            ocupado <= 1'b0;
            for (int n = 0; n < 3; n++) begin
                a_up[n]  <= '0;
                a_low[n] <= '0;
                b_up[n]  <= '0;
                b_low[n] <= '0;
            end
        end else begin
            valido <= 1'b0;
            case (state)
                IDLE: if (inicio) begin
                    a_up[0]  <= A_MF_01_UP;
                    a_low[0] <= A_MF_01_LOW;
                    a_up[1]  <= A_MF_02_UP;
                    a_low[1] <= A_MF_02_LOW;
                    a_up[2]  <= A_MF_03_UP;
                    a_low[2] <= A_MF_03_LOW;
                    b_up[0]  <= B_MF_01_UP;
                    b_low[0] <= B_MF_01_LOW;
                    b_up[1]  <= B_MF_02_UP;
                    b_low[1] <= B_MF_02_LOW;
                    b_up[2]  <= B_MF_03_UP;
                    b_low[2] <= B_MF_03_LOW;
                    num      <= '0;
                    den      <= '0;
                    quo      <= '0;
                    rem      <= '0;
                    cnt      <= '0;
                    ocupado  <= 1'b1;
                    state    <= ACUM;
                end
                ACUM: begin
                    num   <= num + 21'(prod);
                    den   <= den + 13'(w);
                    cnt   <= cnt == 5'd8 ? 5'd0 : cnt + 5'd1;
                    state <= cnt == 5'd8 ? DIV : ACUM;
                end
                // num shifts out MSB-first into the partial remainder
                DIV: begin
                    rem   <= 13'(ge ? rem_sh - {1'b0, den} : rem_sh);
                    quo   <= {quo[19:0], ge};
                    num   <= {num[19:0], 1'b0};
                    cnt   <= cnt == 5'd20 ? 5'd0 : cnt + 5'd1;
                    state <= cnt == 5'd20 ? FIM : DIV;
                end
                FIM: begin
                    saida   <= den == 13'd0 ? SAIDA_PADRAO : |quo[20:8] ? 8'hFF : quo[7:0];
                    valido  <= 1'b1;
                    ocupado <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inferencia_nie_tan.sv
// tb_inferencia_nie_tan: randomized and directed check of the fuzzy inference stage
// against a weighted-average reference and a 31-cycle latency timeline model.
module tb_inferencia_nie_tan;
    localparam int RMAP = 'h29910;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inicio = 1'b0;
    logic [7:0] a_up [3];
    logic [7:0] a_lo [3];
    logic [7:0] b_up [3];
    logic [7:0] b_lo [3];
    logic [7:0] saida;
    logic       valido;
    logic       ocupado;
    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;
    int m_busy = 0;
    int m_age = 0;
    int m_valid = 0;
    int m_out = 0;
    int m_res = 0;

    always #5 clk = ~clk;

    inferencia_nie_tan dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio),
        .A_MF_01_UP(a_up[0]), .A_MF_01_LOW(a_lo[0]),
        .A_MF_02_UP(a_up[1]), .A_MF_02_LOW(a_lo[1]),
        .A_MF_03_UP(a_up[2]), .A_MF_03_LOW(a_lo[2]),
        .B_MF_01_UP(b_up[0]), .B_MF_01_LOW(b_lo[0]),
        .B_MF_02_UP(b_up[1]), .B_MF_02_LOW(b_lo[1]),
        .B_MF_03_UP(b_up[2]), .B_MF_03_LOW(b_lo[2]),
        .saida(saida), .valido(valido), .ocupado(ocupado)
    );

    function automatic int mn(input int x, input int y);
        return x < y ? x : y;
    endfunction

    // Weighted average of singletons over the 3x3 rule base, straight from the rules.
    function automatic int ref_out();
        int ys[3] = '{40, 128, 215};
        int num = 0;
        int den = 0;
        int w;
        int sel;
        int q;
        for (int r = 0; r < 9; r++) begin
            sel = (RMAP >> (2 * r)) & 3;
            w = mn(int'(a_up[r / 3]), int'(b_up[r % 3])) + mn(int'(a_lo[r / 3]), int'(b_lo[r % 3]));
            if (sel != 3) begin
                num += w * ys[sel];
                den += w;
            end
        end
        if (den == 0) return 128;
        q = num / den;
        return q > 255 ? 255 : q;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: busy for 31 edges after an accepted start, result shown on the 31st.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_age = 0;
            m_valid = 0;
            m_out = 0;
        end else begin
            m_valid = 0;
            if (m_busy != 0) begin
                m_age++;
                if (m_age == 31) begin
                    m_busy = 0;
                    m_valid = 1;
                    m_out = m_res;
                end
            end else if (inicio) begin
                m_busy = 1;
                m_age = 0;
                m_res = ref_out();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("valido", int'(valido), m_valid);
            check("ocupado", int'(ocupado), m_busy);
            check("saida", int'(saida), m_out);
        end
    end

    task automatic zero_inputs();
        for (int n = 0; n < 3; n++) begin
            a_up[n] = 8'd0;
            a_lo[n] = 8'd0;
            b_up[n] = 8'd0;
            b_lo[n] = 8'd0;
        end
    endtask

    function automatic logic [7:0] rnd_mf();
        return $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom_range(0, 255));
    endfunction

    task automatic rand_inputs();
        for (int n = 0; n < 3; n++) begin
            a_up[n] = rnd_mf();
            a_lo[n] = rnd_mf();
            b_up[n] = rnd_mf();
            b_lo[n] = rnd_mf();
        end
    endtask

    task automatic pulse();
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valido && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_case(input string name, input int exp);
        int lat;
        check({name, "_model"}, ref_out(), exp);
        pulse();
        wait_valid(lat);
        check({name, "_latency"}, lat, 31);
        check({name, "_saida"}, int'(saida), exp);
    endtask

    initial begin
        int lat;
        int exp1;
        int exp2;
        zero_inputs();
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("reset_saida", int'(saida), 0);
        check("reset_valido", int'(valido), 0);
        check("reset_ocupado", int'(ocupado), 0);
        rst_n = 1'b1;
        @(negedge clk);

        a_up[0] = 8'd255; a_lo[0] = 8'd255; b_up[0] = 8'd255; b_lo[0] = 8'd255;
        run_case("single_rule", 40);

        zero_inputs();
        a_up[0] = 8'd255; a_lo[0] = 8'd255;
        b_up[0] = 8'd128; b_lo[0] = 8'd64; b_up[2] = 8'd128; b_lo[2] = 8'd64;
        @(negedge clk);
        run_case("two_rules", 84);

        zero_inputs();
        a_up[0] = 8'd255; b_up[0] = 8'd1; b_up[2] = 8'd2;
        repeat (2) @(negedge clk);
        run_case("truncation", 98);

        zero_inputs();
        @(negedge clk);
        run_case("zero_weight", 128);

        rand_inputs();
        exp1 = ref_out();
        pulse();
        repeat (2) @(negedge clk);
        rand_inputs();
        repeat (2) @(negedge clk);
        pulse();
        wait_valid(lat);
        check("busy_latency", lat, 26);
        check("busy_saida", int'(saida), exp1);
        exp2 = ref_out();
        pulse();
        wait_valid(lat);
        check("b2b_latency", lat, 31);
        check("b2b_saida", int'(saida), exp2);

        @(negedge clk);
        rand_inputs();
        pulse();
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_saida", int'(saida), 0);
        check("abort_valido", int'(valido), 0);
        check("abort_ocupado", int'(ocupado), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        zero_inputs();
        a_up[0] = 8'd255; a_lo[0] = 8'd255; b_up[0] = 8'd255; b_lo[0] = 8'd255;
        run_case("after_reset", 40);

        for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rand_inputs();
            exp1 = ref_out();
            pulse();
            if ($urandom_range(0, 1) == 1) rand_inputs();
            wait_valid(lat);
            check("rand_latency", lat, 31);
            check("rand_saida", int'(saida), exp1);
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inferencia_nie_tan.md
# inferencia_nie_tan

Type-2 fuzzy inference and defuzzification stage that sits directly downstream of two fuzzifier instances, one per crisp input. On a start pulse it latches both inputs' three upper/lower trapezoid memberships and evaluates the 3x3 rule base sequentially with a min t-norm. It then applies Nie-Tan type reduction as a weighted average of singleton consequents, using a multi-cycle restoring divider. The result is one 8-bit crisp output with a one-cycle valid strobe.

## Interface
- `Y1`, default 8'd40: singleton consequent value for output set 0.
- `Y2`, default 8'd128: singleton consequent value for output set 1.
- `Y3`, default 8'd215: singleton consequent value for output set 2.
- `RULE_MAP`, default 18'h29910: rule r (bits [2r+1:2r]) selects its consequent. 0→Y1, 1→Y2, 2→Y3, 3→rule disabled (weight 0). Default per rule 0..8: 0,0,1,0,1,2,1,2,2.
- `SAIDA_PADRAO`, default 8'd128: output when total weight is zero.
- `clk`  in  1: the only clock; all state is updated on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `inicio`  in  1: start request, sampled only in IDLE.
- `A_MF_01_UP`, `A_MF_01_LOW`, `A_MF_02_UP`, `A_MF_02_LOW`, `A_MF_03_UP`, `A_MF_03_LOW`  in  8 each: input A memberships (0..255).
- `B_MF_01_UP` … `B_MF_03_LOW`  in  8 each: input B memberships, same layout as input A.
- `saida`  out  8: crisp result, held until the next result.
- `valido`  out  1: one-cycle pulse when `saida` updates.
- `ocupado`  out  1: high while a computation is in progress.

## Operation
- Rule index r = 3*i + j, where i is the input A set (0..2) and j is the input B set (0..2).
- Firing strengths: f_up = min(A_i_UP, B_j_UP) and f_low = min(A_i_LOW, B_j_LOW).
- Rule weight w = f_up + f_low, 9 bits unsigned. A disabled rule has w = 0.
- Nie-Tan reduction: saida = floor(Σ w·Y / Σ w).
  - Numerator `num` is 21 bits; its maximum is 9·510·255 = 1,170,450.
  - Denominator `den` is 13 bits; its maximum is 4,590.
- States:
  - IDLE: `inicio`=1 latches all 12 membership inputs, clears `num`, `den` and the rule counter, and moves to ACUM.
  - ACUM: accumulates one rule per cycle for r = 0..8, then moves to DIV.
  - DIV: runs 21 restoring-division iterations of `num` by `den`, one quotient bit per cycle, MSB first, then moves to FIM.
  - FIM: loads `saida` and returns to IDLE.
- In FIM:
  - If `den`=0, `saida` = SAIDA_PADRAO.
  - Otherwise `saida` = quotient; any quotient above 255 saturates to 255.
- Input memberships may change freely once latched; only the latched copy is used.
- `inicio` outside IDLE is ignored. It is not queued.
- The rule base is always fully traversed. Zero-weight rules cost a cycle but add nothing.

## Timing
- Reset (`rst_n`=0, asynchronous) sets:
  - outputs: `saida`=0, `valido`=0, `ocupado`=0;
  - internal state: state=IDLE; `num`, `den`, quotient, remainder and rule counter all 0.
- Reset asserted mid-computation aborts immediately; no `valido` is produced.
- Let edge k be the edge that samples `inicio`=1 in IDLE:
  - `ocupado`=1 from edge k.
  - Edges k+1 .. k+9 accumulate rules 0..8.
  - Edges k+10 .. k+30 perform division steps 1..21.
  - Edge k+31 (FIM) loads `saida`, sets `valido`=1 and `ocupado`=0, and returns to IDLE.
- `valido` deasserts at edge k+32.
- Fixed latency: 31 cycles from the `inicio` sample to `valido`.
- Back-to-back operation: `inicio`=1 in the cycle where `valido`=1 is accepted at edge k+32.
- `saida` is stable at all times except at the FIM edge.

## Test plan
- Single rule, default parameters:
  - stimulus: A_MF_01 UP/LOW = 255/255, B_MF_01 UP/LOW = 255/255, all others 0; pulse `inicio`.
  - required: `valido` exactly 31 cycles later, `saida`=40, `ocupado` high for cycles k..k+30.
- Two rules, weighted average:
  - stimulus: A_MF_01 = 255/255, B_MF_01 = 128/64, B_MF_03 = 128/64 (rule 0→Y1, rule 2→Y2).
  - required: `saida` = (192·40 + 192·128)/384 = 84.
- Truncation:
  - stimulus: A_MF_01 = 255/0, B_MF_01 UP = 1, B_MF_03 UP = 2, all LOW = 0.
  - required: `saida` = floor(296/3) = 98.
- Zero weight:
  - stimulus: all memberships 0.
  - required: `saida`=128 (SAIDA_PADRAO), `valido` pulses normally.
- Busy and input change:
  - stimulus: during a computation, re-pulse `inicio` at k+5 and change all inputs at k+3.
  - required: single `valido` at k+31 carrying the original result. Then a new `inicio` in the `valido` cycle yields its own `valido` 31 cycles later.
- Reset mid-operation:
  - stimulus: drop `rst_n` at k+15.
  - required: `ocupado`=0, `saida`=0 and `valido`=0 immediately. No pulse appears at k+31. The next start produces the correct result.
